// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// FSM state encoding, default sizing and one-hot/index conversion.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ = 8;
    localparam int DEF_ID_W    = 3;

    // Widest supported configuration; callers size-cast to their own width.
    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_ID_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

    function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// Rotating-priority encoder: first set bit of req at or above ptr,
// wrapping to the lowest set bit when nothing at or above ptr is requesting.
module rr_pri_enc
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] sel;
    logic [NUM_REQ-1:0] pick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign mask[gi] = (ID_W'(gi) >= ptr);
        end
    endgenerate

    assign masked = req & mask;
    assign sel    = (|masked) ? masked : req;
    // Isolate the lowest set bit of the selected vector.
    assign pick   = sel & (~sel + NUM_REQ'(1));
    assign winner = ID_W'(onehot_to_idx(MAX_REQ'(pick)));
    assign valid  = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter with registered one-hot grant and done/req-drop release.
// Optional hold-time limit with forced release is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_W     = DEF_ID_W
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    arb_state_t         state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [ID_W-1:0]    grant_id_reg, grant_id_next;
    logic               grant_valid_reg, grant_valid_next;

    logic [ID_W-1:0]    enc_winner;
    logic               enc_valid;
    logic               force_rel;
    logic               release_now;

    rr_pri_enc #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pri_enc (
        .req     (req),
        .ptr     (ptr_reg),
        .winner  (enc_winner),
        .valid   (enc_valid)
    );

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_next       = grant_reg;
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        // IDLE always arbitrates; BUSY only once the owner lets go or is forced off.
        release_now = (state_reg == IDLE) | done | ~req[grant_id_reg] | force_rel;
        if (release_now) begin
            if (enc_valid) begin
                state_next       = BUSY;
                grant_next       = NUM_REQ'(idx_to_onehot(MAX_ID_W'(enc_winner)));
                grant_id_next    = enc_winner;
                grant_valid_next = 1'b1;
                ptr_next         = enc_winner + ID_W'(1);
            end else begin
                state_next       = IDLE;
                grant_next       = '0;
                grant_id_next    = '0;
                grant_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_reg       <= '0;
            grant_id_reg    <= '0;
            grant_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             timeout_reg;

    // A simultaneous done or req drop wins over the limit, so no pulse then.
    assign force_rel = (state_reg == BUSY) && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1))
                       && !done && req[grant_id_reg];

    always_comb begin
        hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        if (release_now) begin
            hold_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= force_rel;
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a round-robin reference model predicts each
// cycle's outputs, a monitor pops and compares them one cycle later.
module tb_rr_arbiter_8;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;
    bit   mon_en   = 1'b0;

    // Reference state: current owner (-1 = none), next priority position,
    // and how many cycles the owner has held the grant so far.
    int owner = -1;
    int ptr   = 0;
    int held  = 0;

    rr_arbiter_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        owner = -1;
        ptr   = 0;
        held  = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d, output exp_t e);
        bit rel;
        bit forced;
        int w;
        forced = 1'b0;
        if (owner < 0) begin
            rel = 1'b1;
        end else begin
            rel = d || !r[owner];
            if (!rel && TO_EN && held == MAX_HOLD) begin
                rel    = 1'b1;
                forced = 1'b1;
            end
        end
        if (rel) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (w < 0 && r[i]) w = i;
            end
            if (w >= 0) begin
                owner = w;
                ptr   = (w + 1) % N;
                held  = 1;
            end else begin
                owner = -1;
                held  = 0;
            end
        end else begin
            held++;
        end
        e.grant   = (owner < 0) ? 8'h00 : 8'(1 << owner);
        e.id      = (owner < 0) ? 3'd0 : 3'(owner);
        e.valid   = (owner >= 0);
        e.timeout = forced;
    endtask

    task automatic cycle(input logic [7:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d, e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end else begin
            $display("check %s value=%h", name, act);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            checks++;
            if ({grant, grant_id, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL txn=%0d req=%h done=%b got grant=%h id=%0d valid=%b timeout=%b want grant=%h id=%0d valid=%b timeout=%b",
                         txn, req, done, grant, grant_id, grant_valid, timeout,
                         e.grant, e.id, e.valid, e.timeout);
            end else begin
                $display("txn=%0d req=%h done=%b grant=%h id=%0d valid=%b timeout=%b",
                         txn, req, done, grant, grant_id, grant_valid, timeout);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_id_valid_to", 32'({grant_id, grant_valid, timeout}), 32'h0);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Idle with no requests.
        repeat (5) cycle(8'h00, 1'b0);

        // Single requester 3, then release with req dropped.
        cycle(8'h08, 1'b0);
        cycle(8'h08, 1'b0);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        // All requesting, done every second cycle: back-to-back rotation.
        for (int i = 0; i < 20; i++) cycle(8'hFF, (i % 2) == 1);
        repeat (2) cycle(8'h00, 1'b1);

        // Owner 5, done with requester 0 pending wraps past 7; then owner drops req.
        cycle(8'h20, 1'b0);
        cycle(8'h21, 1'b1);
        cycle(8'h21, 1'b0);
        cycle(8'h20, 1'b0);
        cycle(8'h20, 1'b0);
        repeat (2) cycle(8'h00, 1'b1);

        // Asynchronous reset while requester 6 owns the grant.
        cycle(8'h40, 1'b0);
        cycle(8'h40, 1'b0);
        @(posedge clk);
        #3;
        check("pre_reset_grant", 32'(grant), 32'h40);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_grant", 32'(grant), 32'h0);
        check("async_reset_valid_id", 32'({grant_id, grant_valid}), 32'h0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycle(8'h40, 1'b0);
        cycle(8'h40, 1'b0);
        repeat (2) cycle(8'h00, 1'b1);

        // Two requesters, never done: hold limit behaviour (or indefinite hold).
        repeat (40) cycle(8'h03, 1'b0);
        repeat (2) cycle(8'h00, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] r;
            logic       d;
            r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = ($urandom_range(0, 3) == 0);
            cycle(r, d);
        end

        // Long holds under random side traffic, owner keeps requesting.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] r;
            r = 8'($urandom) | 8'h01;
            cycle(r, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
